// File: rtl/ej32_pkg.sv
// ej32 shared types for the memory arbiter: FSM states, read owner
// tags and the default locked-burst length.
package ej32_pkg;

  typedef enum logic {
    IDLE,
    LS_LOCK
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } arb_owner_t;

  localparam int unsigned ARB_MAX_BEATS = 4;

endpackage

// File: rtl/ej32_mem_arb_rsp.sv
// ej32 arbiter response stage: remembers who issued the read and
// returns the captured byte with a per-requester valid.
module ej32_mem_arb_rsp
  import ej32_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_if,
  input  logic       rd_ls,
  input  logic [7:0] mem_rdata,
  output logic       if_rvld,
  output logic       ls_rvld,
  output logic [7:0] rdata
);

  arb_owner_t owner;

  // writes leave rdata alone so an older read result survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_NONE;
      rdata <= '0;
    end else begin
      unique case (1'b1)
        rd_ls:   owner <= OWN_LS;
        rd_if:   owner <= OWN_IF;
        default: owner <= OWN_NONE;
      endcase
      if (rd_ls || rd_if) rdata <= mem_rdata;
    end
  end

  assign if_rvld = (owner == OWN_IF);
  assign ls_rvld = (owner == OWN_LS);

endmodule

// File: rtl/ej32_mem_arb.sv
// ej32 byte memory port arbiter between fetch and load/store.
// Define EJ32_ARB_STARVE_EN to force an IF grant after STARVE_N LS wins.
module ej32_mem_arb
  import ej32_pkg::*;
#(
  parameter int unsigned ASZ       = 16,
  parameter int unsigned MAX_BEATS = ARB_MAX_BEATS,
  parameter int unsigned STARVE_N  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req,
  input  logic [ASZ-1:0] if_addr,
  output logic           if_gnt,
  output logic           if_rvld,
  input  logic           ls_req,
  input  logic           ls_we,
  input  logic [ASZ-1:0] ls_addr,
  input  logic [7:0]     ls_wdata,
  input  logic           ls_lock,
  output logic           ls_gnt,
  output logic           ls_rvld,
  output logic [7:0]     rdata,
  output logic           mem_en,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_addr,
  output logic [7:0]     mem_wdata,
  input  logic [7:0]     mem_rdata,
  output logic           lock_ovf
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  arb_state_t    state;
  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] beat_nxt;
  logic          starve_force;

  assign beat_nxt = beat_cnt + BW'(1);

`ifdef EJ32_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_N + 1);

  logic [SW-1:0] starve_cnt;

  assign starve_force = (state == IDLE) && if_req &&
                        (starve_cnt == SW'(STARVE_N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && ls_gnt && if_req &&
                 (starve_cnt != SW'(STARVE_N))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  logic unused_starve_n;

  assign starve_force    = 1'b0;
  assign unused_starve_n = (STARVE_N != 0);
`endif

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (state == LS_LOCK) ls_gnt = ls_req;
      else if (starve_force) if_gnt = 1'b1;
      else if (ls_req) ls_gnt = 1'b1;
      else if_gnt = if_req;
    end
  end

  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = ls_gnt & ls_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // hitting MAX_BEATS with lock still set drops to a fresh arbitration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      lock_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_gnt && ls_lock) begin
            state    <= LS_LOCK;
            beat_cnt <= BW'(1);
          end
        end
        LS_LOCK: begin
          if (ls_gnt) begin
            if (!ls_lock) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else if (beat_nxt == BW'(MAX_BEATS)) begin
              state    <= IDLE;
              beat_cnt <= '0;
              lock_ovf <= 1'b1;
            end else begin
              beat_cnt <= beat_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ej32_mem_arb_rsp u_rsp (
    .clk       (clk),
    .rst       (rst),
    .rd_if     (if_gnt),
    .rd_ls     (ls_gnt & ~ls_we),
    .mem_rdata (mem_rdata),
    .if_rvld   (if_rvld),
    .ls_rvld   (ls_rvld),
    .rdata     (rdata)
  );

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed bench for ej32_mem_arb: grant priority, lock bursts,
// overflow, optional starvation rule, read/write order and reset.
module tb_ej32_mem_arb;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvld;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [7:0]  ls_wdata;
  logic        ls_lock;
  logic        ls_gnt;
  logic        ls_rvld;
  logic [7:0]  rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        lock_ovf;

  int vec;
  int errs;

  ej32_mem_arb #(
    .ASZ       (16),
    .MAX_BEATS (4),
    .STARVE_N  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvld   (if_rvld),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_lock   (ls_lock),
    .ls_gnt    (ls_gnt),
    .ls_rvld   (ls_rvld),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .lock_ovf  (lock_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [29:0] got;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 16'h0040;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0080;
    ls_wdata = 8'h00; ls_lock = 1'b1; mem_rdata = 8'hFF;
    cyc(); cyc();
    got = {mem_en, if_gnt, ls_gnt, if_rvld, ls_rvld, lock_ovf, rdata, mem_addr};
    vec++;
    if (got !== 30'h0) begin
      errs++;
      $display("FAIL reset_state got %h want 0", got);
    end
    rst = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_lock = 1'b0;
    #1;
    vec++;
    if ({mem_en, mem_addr, mem_wdata} !== 25'h0) begin
      errs++;
      $display("FAIL idle_bus got %h want 0", {mem_en, mem_addr, mem_wdata});
    end
  endtask

  task automatic test_if_only();
    cyc();
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 8'hB1;
    #1;
    vec++;
    if ({if_gnt, ls_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 16'h0010}) begin
      errs++;
      $display("FAIL if_only.gnt got %b %b %b %b %h want 1 0 1 0 0010",
               if_gnt, ls_gnt, mem_en, mem_we, mem_addr);
    end
    cyc();
    if_req = 1'b0;
    vec++;
    if ({if_rvld, ls_rvld, rdata} !== {2'b10, 8'hB1}) begin
      errs++;
      $display("FAIL if_only.rvld got %b %b %h want 1 0 b1",
               if_rvld, ls_rvld, rdata);
    end
  endtask

  task automatic test_contention();
    cyc();
    if_req = 1'b1; if_addr = 16'h0010;
    ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b0; ls_addr = 16'h0200;
    mem_rdata = 8'h5C;
    #1;
    vec++;
    if ({ls_gnt, if_gnt, mem_addr} !== {2'b10, 16'h0200}) begin
      errs++;
      $display("FAIL contend.ls got %b %b %h want 1 0 0200",
               ls_gnt, if_gnt, mem_addr);
    end
    cyc();
    ls_req = 1'b0;
    #1;
    vec++;
    if ({if_gnt, ls_gnt, ls_rvld, rdata, mem_addr} !== {3'b101, 8'h5C, 16'h0010}) begin
      errs++;
      $display("FAIL contend.retry got %b %b %b %h %h want 1 0 1 5c 0010",
               if_gnt, ls_gnt, ls_rvld, rdata, mem_addr);
    end
    cyc();
    if_req = 1'b0;
    vec++;
    if ({if_rvld, ls_rvld} !== 2'b10) begin
      errs++;
      $display("FAIL contend.if_rvld got %b %b want 1 0", if_rvld, ls_rvld);
    end
  endtask

  task automatic test_lock_burst();
    logic [7:0]  dat[5]  = '{8'hA0, 8'hA1, 8'h00, 8'hA2, 8'hA3};
    logic        req[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        lck[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] adr[5]  = '{16'h0300, 16'h0301, 16'h0000, 16'h0302, 16'h0303};
    logic        xrv[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  xrd[5]  = '{8'h00, 8'hA0, 8'hA1, 8'hA1, 8'hA2};
    for (int i = 0; i < 5; i++) begin
      cyc();
      if_req = 1'b1; if_addr = 16'h0020;
      ls_req = req[i]; ls_we = 1'b0; ls_lock = lck[i];
      ls_addr = adr[i]; mem_rdata = dat[i];
      #1;
      vec++;
      if ({if_gnt, ls_gnt, mem_en} !== {1'b0, req[i], req[i]}) begin
        errs++;
        $display("FAIL burst.gnt[%0d] got %b %b %b want 0 %b %b",
                 i, if_gnt, ls_gnt, mem_en, req[i], req[i]);
      end
      if (i > 0) begin
        vec++;
        if ({ls_rvld, rdata} !== {xrv[i], xrd[i]} && xrv[i]) begin
          errs++;
          $display("FAIL burst.rvld[%0d] got %b %h want %b %h",
                   i, ls_rvld, rdata, xrv[i], xrd[i]);
        end else if (ls_rvld !== xrv[i]) begin
          errs++;
          $display("FAIL burst.rvld[%0d] got %b want %b", i, ls_rvld, xrv[i]);
        end
      end
    end
    cyc();
    ls_req = 1'b0; ls_lock = 1'b0;
    #1;
    vec++;
    if ({if_gnt, ls_rvld, rdata, lock_ovf} !== {2'b11, 8'hA3, 1'b0}) begin
      errs++;
      $display("FAIL burst.release got %b %b %h %b want 1 1 a3 0",
               if_gnt, ls_rvld, rdata, lock_ovf);
    end
    cyc();
    if_req = 1'b0;
  endtask

  task automatic test_lock_ovf();
    for (int i = 0; i < 4; i++) begin
      cyc();
      if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b1;
      ls_addr = 16'h0600 + 16'(i); mem_rdata = 8'h60 + 8'(i);
      #1;
      vec++;
      if ({ls_gnt, lock_ovf} !== 2'b10) begin
        errs++;
        $display("FAIL ovf.beat[%0d] got %b %b want 1 0", i, ls_gnt, lock_ovf);
      end
    end
    cyc();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 16'h0030;
    #1;
    vec++;
    if ({if_gnt, lock_ovf} !== 2'b11) begin
      errs++;
      $display("FAIL ovf.fresh got %b %b want 1 1", if_gnt, lock_ovf);
    end
    cyc();
    if_req = 1'b0; ls_req = 1'b1; ls_lock = 1'b1; ls_addr = 16'h0604;
    #1;
    vec++;
    if ({ls_gnt, lock_ovf} !== 2'b11) begin
      errs++;
      $display("FAIL ovf.beat5 got %b %b want 1 1", ls_gnt, lock_ovf);
    end
    cyc();
    ls_lock = 1'b0; ls_addr = 16'h0605;
    cyc();
    ls_req = 1'b0;
    cyc();
    vec++;
    if (lock_ovf !== 1'b1) begin
      errs++;
      $display("FAIL ovf.sticky got %b want 1", lock_ovf);
    end
  endtask

  task automatic test_starve();
    bit   starve_on;
    logic exp_if;
`ifdef EJ32_ARB_STARVE_EN
    starve_on = 1'b1;
`else
    starve_on = 1'b0;
`endif
    cyc();
    if_req = 1'b1; if_addr = 16'h0044;
    ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b0; ls_addr = 16'h0700;
    for (int i = 0; i < 18; i++) begin
      #1;
      exp_if = starve_on && ((i % 9) == 8);
      vec++;
      if ({if_gnt, ls_gnt} !== {exp_if, ~exp_if}) begin
        errs++;
        $display("FAIL starve[%0d] got if=%b ls=%b want if=%b ls=%b",
                 i, if_gnt, ls_gnt, exp_if, ~exp_if);
      end
      cyc();
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_rd_wr();
    cyc();
    ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b0;
    ls_addr = 16'h0400; mem_rdata = 8'h77;
    #1;
    vec++;
    if ({ls_gnt, mem_we} !== 2'b10) begin
      errs++;
      $display("FAIL rdwr.read got %b %b want 1 0", ls_gnt, mem_we);
    end
    cyc();
    ls_we = 1'b1; ls_addr = 16'h0401; ls_wdata = 8'hEE; mem_rdata = 8'h00;
    #1;
    vec++;
    if ({ls_rvld, rdata, mem_en, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 8'h77, 2'b11, 16'h0401, 8'hEE}) begin
      errs++;
      $display("FAIL rdwr.write got %b %h %b %b %h %h want 1 77 1 1 0401 ee",
               ls_rvld, rdata, mem_en, mem_we, mem_addr, mem_wdata);
    end
    cyc();
    ls_req = 1'b0; ls_we = 1'b0; ls_wdata = 8'h00;
    #1;
    vec++;
    if ({ls_rvld, if_rvld, rdata, mem_en, mem_addr, mem_wdata} !==
        {2'b00, 8'h77, 1'b0, 16'h0000, 8'h00}) begin
      errs++;
      $display("FAIL rdwr.after got %b %b %h %b %h %h want 0 0 77 0 0000 00",
               ls_rvld, if_rvld, rdata, mem_en, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] got;
    cyc();
    if_req = 1'b1; if_addr = 16'h0020;
    ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b1;
    ls_addr = 16'h0500; mem_rdata = 8'h11;
    cyc();
    ls_addr = 16'h0501; mem_rdata = 8'h12;
    #1;
    rst = 1'b1;
    #1;
    got = {mem_en, if_gnt, ls_gnt, if_rvld, ls_rvld, lock_ovf, rdata};
    vec++;
    if (got !== 14'h0) begin
      errs++;
      $display("FAIL rst_mid got %h want 0", got);
    end
    cyc();
    rst = 1'b0; ls_req = 1'b0; ls_lock = 1'b0;
    if_req = 1'b1; if_addr = 16'h0020; mem_rdata = 8'h33;
    #1;
    vec++;
    if ({if_gnt, ls_gnt, mem_addr} !== {2'b10, 16'h0020}) begin
      errs++;
      $display("FAIL rst_mid.if got %b %b %h want 1 0 0020",
               if_gnt, ls_gnt, mem_addr);
    end
    cyc();
    if_req = 1'b0;
    vec++;
    if ({if_rvld, ls_rvld, rdata} !== {2'b10, 8'h33}) begin
      errs++;
      $display("FAIL rst_mid.rvld got %b %b %h want 1 0 33",
               if_rvld, ls_rvld, rdata);
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_if_only();
    test_contention();
    test_lock_burst();
    test_lock_ovf();
    test_starve();
    test_rd_wr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
